// File: rtl/cordic_sincos_frontend.sv
// cordic_sincos_frontend
//   Full-range sin/cos sequencer wrapped around a CORDIC rotator. Takes an
//   S7.24 angle, brings it into [-pi, pi] by 2*pi steps (one per cycle),
//   folds it into [-pi/2, pi/2] (recording a sign flip), starts the rotator,
//   then sign-corrects the rotator result and holds it on the output port.
//   One request in flight at a time.
// Ports
//   clk, resetn                  clock, async active-low reset
//   in_valid/in_ready/in_angle   request port, S7.24 radians
//   out_valid/out_ready          result port
//   out_cos/out_sin              S1.30 result, held until the next capture
//   cordic_calculate             one-cycle start pulse to the rotator
//   cordic_angle                 S1.30 angle to the rotator
//   cordic_busy                  rotator busy
//   cordic_cos/cordic_sin        rotator S1.30 results
module cordic_sincos_frontend #(
  parameter logic signed [31:0] TWO_PI_Q24  = 32'sd105414357,
  parameter logic signed [31:0] PI_Q24      = 32'sd52707179,
  parameter logic signed [31:0] HALF_PI_Q24 = 32'sd26353589
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_angle,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_cos,
  output logic [31:0] out_sin,
  output logic        cordic_calculate,
  output logic [31:0] cordic_angle,
  input  logic        cordic_busy,
  input  logic [31:0] cordic_cos,
  input  logic [31:0] cordic_sin
);

  typedef enum logic [2:0] {
    S_IDLE, S_REDUCE, S_FOLD, S_LAUNCH, S_WAIT, S_OUTPUT
  } state_e;

  state_e             state_q, state_d;
  logic signed [31:0] a_q, a_d;
  logic               neg_q, neg_d;
  logic [31:0]        cang_q, cang_d;
  logic [31:0]        cos_q, cos_d;
  logic [31:0]        sin_q, sin_d;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= S_IDLE;
      a_q     <= '0;
      neg_q   <= 1'b0;
      cang_q  <= '0;
      cos_q   <= '0;
      sin_q   <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      neg_q   <= neg_d;
      cang_q  <= cang_d;
      cos_q   <= cos_d;
      sin_q   <= sin_d;
    end
  end

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    neg_d   = neg_q;
    cang_d  = cang_q;
    cos_d   = cos_q;
    sin_d   = sin_q;
    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          a_d     = signed'(in_angle);
          neg_d   = 1'b0;
          state_d = S_REDUCE;
        end
      end
      // +-pi exactly is treated as in range; the S7.24 input range bounds
      // this loop to at most 21 steps and no intermediate overflows.
      S_REDUCE: begin
        if (a_q > PI_Q24)       a_d = a_q - TWO_PI_Q24;
        else if (a_q < -PI_Q24) a_d = a_q + TWO_PI_Q24;
        else                    state_d = S_FOLD;
      end
      // Shifting by pi negates both sin and cos; remember it for the output.
      // The folded angle is registered for the rotator here so it is stable
      // through LAUNCH and the whole rotation.
      S_FOLD: begin
        if (a_q > HALF_PI_Q24) begin
          a_d   = a_q - PI_Q24;
          neg_d = 1'b1;
        end else if (a_q < -HALF_PI_Q24) begin
          a_d   = a_q + PI_Q24;
          neg_d = 1'b1;
        end
        cang_d  = a_d <<< 6;
        state_d = S_LAUNCH;
      end
      S_LAUNCH: state_d = S_WAIT;
      // The rotator raises busy on the edge that sees the start pulse, so
      // the first busy=0 seen here is the finished result.
      S_WAIT: begin
        if (!cordic_busy) begin
          cos_d   = neg_q ? -cordic_cos : cordic_cos;
          sin_d   = neg_q ? -cordic_sin : cordic_sin;
          state_d = S_OUTPUT;
        end
      end
      S_OUTPUT: begin
        if (out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign in_ready         = (state_q == S_IDLE);
  assign out_valid        = (state_q == S_OUTPUT);
  assign cordic_calculate = (state_q == S_LAUNCH);
  assign cordic_angle     = cang_q;
  assign out_cos          = cos_q;
  assign out_sin          = sin_q;

endmodule
